vram_arbiter: RTL

- Shares one port of the EpochTV1 dual-port VRAM between three requesters:
  - VID: video fetch, hard real-time, highest priority.
  - DMA: DMA engine.
  - CPU: CPU bus interface.
- Issues at most one RAM access per clock, drives the RAM port's active-low strobes, and routes registered read data back to the requester that issued the read.
- A wait counter guarantees the CPU bounded latency against continuous DMA traffic.

---
 rtl/epochtv1_pkg.sv | 14 +
 rtl/vram_arb_pri.sv | 24 ++
 rtl/vram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/epochtv1_pkg.sv
// rtl/epochtv1_pkg.sv - shared EpochTV1 VRAM constants and owner encoding
package epochtv1_pkg;

    localparam int VRAM_AWIDTH = 12;
    localparam int VRAM_DWIDTH = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_t;

endpackage

// File: rtl/vram_arb_pri.sv
// rtl/vram_arb_pri.sv - fixed-priority encoder for the VRAM port owner
module vram_arb_pri
    import epochtv1_pkg::*;
(
    input  logic [2:0] req,         // [0]=VID, [1]=DMA, [2]=CPU pending
    input  logic       cpu_urgent,  // CPU has lost enough grants to outrank DMA
    output owner_t     owner
);

    // VID always first; an urgent CPU jumps ahead of DMA, otherwise CPU is last
    always_comb begin
        owner = OWN_NONE;
        if (req[0]) begin
            owner = OWN_VID;
        end else if (req[2] && cpu_urgent) begin
            owner = OWN_CPU;
        end else if (req[1]) begin
            owner = OWN_DMA;
        end else if (req[2]) begin
            owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - three-way arbiter for one EpochTV1 VRAM port
module vram_arbiter
    import epochtv1_pkg::*;
#(
    parameter int DWIDTH  = VRAM_DWIDTH,
    parameter int AWIDTH  = VRAM_AWIDTH,
    parameter int MAXWAIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              VID_REQ,
    input  logic [AWIDTH-1:0] VID_A,
    output logic              VID_ACK,
    output logic              VID_RVALID,
    input  logic              DMA_REQ,
    input  logic              DMA_WE,
    input  logic [AWIDTH-1:0] DMA_A,
    input  logic [DWIDTH-1:0] DMA_DI,
    output logic              DMA_ACK,
    output logic              DMA_RVALID,
    input  logic              CPU_STB,
    input  logic              CPU_WE,
    input  logic [AWIDTH-1:0] CPU_A,
    input  logic [DWIDTH-1:0] CPU_DI,
    output logic              CPU_BUSY,
    output logic              CPU_RVALID,
    output logic [DWIDTH-1:0] RDATA,
    output logic              nCE,
    output logic              nWE,
    output logic              nOE,
    output logic [AWIDTH-1:0] A,
    output logic [DWIDTH-1:0] DI,
    input  logic [DWIDTH-1:0] DO
);

    localparam logic [3:0] WAIT_MAX = 4'd15;

    logic              cpu_pend;
    logic              cpu_we;
    logic [AWIDTH-1:0] cpu_a;
    logic [DWIDTH-1:0] cpu_di;
    logic [3:0]        wait_cnt;
    owner_t            rd_tag;

    logic              cpu_urgent;
    owner_t            pri_owner;
    owner_t            owner;
    logic              issue_we;

    assign cpu_urgent = (wait_cnt >= 4'(MAXWAIT));

    vram_arb_pri u_pri (
        .req        ({cpu_pend, DMA_REQ, VID_REQ}),
        .cpu_urgent (cpu_urgent),
        .owner      (pri_owner)
    );

    // Nothing may reach the RAM while reset is held, even with requests active
    assign owner = nRST ? pri_owner : OWN_NONE;

    // Route the winner's address, data and direction onto the RAM port
    always_comb begin
        issue_we = 1'b0;
        A        = '0;
        DI       = '0;
        case (owner)
            OWN_VID: begin
                A = VID_A;
            end
            OWN_DMA: begin
                A        = DMA_A;
                DI       = DMA_DI;
                issue_we = DMA_WE;
            end
            OWN_CPU: begin
                A        = cpu_a;
                DI       = cpu_di;
                issue_we = cpu_we;
            end
            default: ;
        endcase
    end

    assign nCE     = (owner == OWN_NONE);
    assign nWE     = nCE | ~issue_we;
    assign nOE     = nCE | issue_we;
    assign VID_ACK = (owner == OWN_VID);
    assign DMA_ACK = (owner == OWN_DMA);

    // Single-entry CPU holding register: capture when idle, release on issue
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cpu_pend <= 1'b0;
            cpu_we   <= 1'b0;
            cpu_a    <= '0;
            cpu_di   <= '0;
        end else if (cpu_pend) begin
            if (owner == OWN_CPU) begin
                cpu_pend <= 1'b0;
            end
        end else if (CPU_STB) begin
            cpu_pend <= 1'b1;
            cpu_we   <= CPU_WE;
            cpu_a    <= CPU_A;
            cpu_di   <= CPU_DI;
        end
    end

    // Count DMA grants that overtook a pending CPU access; VID grants are free
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= 4'd0;
        end else if (!cpu_pend || owner == OWN_CPU) begin
            wait_cnt <= 4'd0;
        end else if (owner == OWN_DMA && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Remember who issued a read so the registered RAM data goes back to them
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_tag <= OWN_NONE;
        end else if (owner != OWN_NONE && !issue_we) begin
            rd_tag <= owner;
        end else begin
            rd_tag <= OWN_NONE;
        end
    end

    assign CPU_BUSY   = cpu_pend;
    assign VID_RVALID = (rd_tag == OWN_VID);
    assign DMA_RVALID = (rd_tag == OWN_DMA);
    assign CPU_RVALID = (rd_tag == OWN_CPU);
    assign RDATA      = DO;

endmodule
